// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, frame length, command bytes.
package ps2_pkg;

   // Host-transmit FSM state encoding
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] INHIBIT   = 3'd1;
   localparam logic [2:0] REQ       = 3'd2;
   localparam logic [2:0] SEND      = 3'd3;
   localparam logic [2:0] ACK       = 3'd4;
   localparam logic [2:0] WAIT_IDLE = 3'd5;
   localparam logic [2:0] ERROR     = 3'd6;

   // Start + 8 data + parity + stop
   localparam int unsigned PS2_FRAME_BITS = 11;

   // Common keyboard commands
   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data lines with a registered
// falling-edge pulse on the clock line. Pin-to-pulse latency is 3 clk cycles.
// Lines idle high, so the flops reset to 1 to avoid a spurious edge.
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   output logic sync_clk,
   output logic sync_data,
   output logic clk_fall
);

   logic clk_meta;
   logic data_meta;
   logic clk_prev;

   // Synchronize both lines and register the clock falling edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_meta  <= 1'b1;
         data_meta <= 1'b1;
         sync_clk  <= 1'b1;
         sync_data <= 1'b1;
         clk_prev  <= 1'b1;
         clk_fall  <= 1'b0;
      end else begin
         clk_meta  <= ps2_clk_in;
         data_meta <= ps2_data_in;
         sync_clk  <= clk_meta;
         sync_data <= data_meta;
         clk_prev  <= sync_clk;
         clk_fall  <= clk_prev & ~sync_clk;
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits LSB
// first, odd parity, stop, then device ACK check with an overall timeout.
// Optional build macro: PS2_TX_RESEND_EN (one automatic resend on failure).
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_drive_low,
   output logic       ps2_data_drive_low,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0] PARITY_IDX = 4'(PS2_FRAME_BITS - 3);

   logic             sync_clk;
   logic             sync_data;
   logic             clk_fall;

   logic [2:0]       state,    state_d;
   logic [CNT_W-1:0] cnt,      cnt_d;
   logic [3:0]       bit_cnt,  bit_cnt_d;
   logic [7:0]       byte_q,   byte_d;
   logic             parity_q, parity_d;
   logic             clk_dl_d, data_dl_d;
   logic             ready_d, done_d, error_d;
   logic             fail_c;
   logic [CNT_W-1:0] cnt_inc_c;
`ifdef PS2_TX_RESEND_EN
   logic             retry_q, retry_d;
`endif

   ps2_line_sync u_sync (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .sync_clk    (sync_clk),
      .sync_data   (sync_data),
      .clk_fall    (clk_fall)
   );

   // Saturating increment for the shared counter
   assign cnt_inc_c = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   // Next-state and next-output logic
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      bit_cnt_d = bit_cnt;
      byte_d    = byte_q;
      parity_d  = parity_q;
      clk_dl_d  = ps2_clk_drive_low;
      data_dl_d = ps2_data_drive_low;
      done_d    = 1'b0;
      error_d   = 1'b0;
      fail_c    = 1'b0;
`ifdef PS2_TX_RESEND_EN
      retry_d   = retry_q;
`endif

      case (state)
         IDLE: begin
`ifdef PS2_TX_RESEND_EN
            retry_d = 1'b0;
`endif
            if (tx_valid && tx_ready) begin
               byte_d    = tx_data;
               parity_d  = ~^tx_data;
               state_d   = INHIBIT;
               clk_dl_d  = 1'b1;
               data_dl_d = 1'b0;
               cnt_d     = '0;
               bit_cnt_d = '0;
            end
         end
         INHIBIT: begin
            if (cnt == INH_LAST) begin
               state_d   = REQ;
               data_dl_d = 1'b1;
            end else begin
               cnt_d = cnt_inc_c;
            end
         end
         REQ: begin
            state_d   = SEND;
            clk_dl_d  = 1'b0;
            cnt_d     = '0;
            bit_cnt_d = '0;
         end
         SEND: begin
            cnt_d = cnt_inc_c;
            if (cnt == TO_LAST) begin
               fail_c = 1'b1;
            end else if (clk_fall) begin
               bit_cnt_d = bit_cnt + 4'd1;
               if (bit_cnt < PARITY_IDX) begin
                  data_dl_d = ~byte_q[bit_cnt[2:0]];
               end else if (bit_cnt == PARITY_IDX) begin
                  data_dl_d = ~parity_q;
               end else begin
                  data_dl_d = 1'b0;
                  state_d   = ACK;
               end
            end
         end
         ACK: begin
            cnt_d = cnt_inc_c;
            if (cnt == TO_LAST) begin
               fail_c = 1'b1;
            end else if (clk_fall) begin
               bit_cnt_d = bit_cnt + 4'd1;
               if (!sync_data) begin
                  state_d = WAIT_IDLE;
               end else begin
                  fail_c = 1'b1;
               end
            end
         end
         WAIT_IDLE: begin
            cnt_d = cnt_inc_c;
            if (cnt == TO_LAST) begin
               fail_c = 1'b1;
            end else if (sync_clk && sync_data) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         ERROR: begin
            state_d   = IDLE;
            clk_dl_d  = 1'b0;
            data_dl_d = 1'b0;
         end
         default: begin
            state_d   = IDLE;
            clk_dl_d  = 1'b0;
            data_dl_d = 1'b0;
         end
      endcase

      // Failure: NACK or timeout
      if (fail_c) begin
`ifdef PS2_TX_RESEND_EN
         if (!retry_q) begin
            retry_d   = 1'b1;
            state_d   = INHIBIT;
            clk_dl_d  = 1'b1;
            data_dl_d = 1'b0;
            cnt_d     = '0;
            bit_cnt_d = '0;
         end else begin
            state_d   = ERROR;
            clk_dl_d  = 1'b0;
            data_dl_d = 1'b0;
            error_d   = 1'b1;
         end
`else
         state_d   = ERROR;
         clk_dl_d  = 1'b0;
         data_dl_d = 1'b0;
         error_d   = 1'b1;
`endif
      end

      ready_d = (state_d == IDLE);
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= IDLE;
         cnt                <= '0;
         bit_cnt            <= '0;
         byte_q             <= '0;
         parity_q           <= 1'b0;
         ps2_clk_drive_low  <= 1'b0;
         ps2_data_drive_low <= 1'b0;
         tx_ready           <= 1'b1;
         tx_done            <= 1'b0;
         tx_error           <= 1'b0;
`ifdef PS2_TX_RESEND_EN
         retry_q            <= 1'b0;
`endif
      end else begin
         state              <= state_d;
         cnt                <= cnt_d;
         bit_cnt            <= bit_cnt_d;
         byte_q             <= byte_d;
         parity_q           <= parity_d;
         ps2_clk_drive_low  <= clk_dl_d;
         ps2_data_drive_low <= data_dl_d;
         tx_ready           <= ready_d;
         tx_done            <= done_d;
         tx_error           <= error_d;
`ifdef PS2_TX_RESEND_EN
         retry_q            <= retry_d;
`endif
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model (40-cycle clock).
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int unsigned INH = 10;
   localparam int unsigned TO  = 2000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       clk_dl;
   logic       data_dl;
   logic       tx_done;
   logic       tx_error;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int both_hi = 0;
   int inh_run = 0;
   int last_inh = 0;
   int req_cnt = 0;
   int inh_starts = 0;
   logic clk_dl_prev = 1'b0;

   // Open-drain wired-AND of host and device
   assign ps2_clk_in  = ~(clk_dl | dev_clk_low);
   assign ps2_data_in = ~(data_dl | dev_data_low);

   always #5 clk = ~clk;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk                (clk),
      .rst                (rst),
      .tx_data            (tx_data),
      .tx_valid           (tx_valid),
      .tx_ready           (tx_ready),
      .ps2_clk_in         (ps2_clk_in),
      .ps2_data_in        (ps2_data_in),
      .ps2_clk_drive_low  (clk_dl),
      .ps2_data_drive_low (data_dl),
      .tx_done            (tx_done),
      .tx_error           (tx_error)
   );

   // Pulse and line-phase monitor
   always @(negedge clk) begin
      if (tx_done) done_cnt <= done_cnt + 1;
      if (tx_error) err_cnt <= err_cnt + 1;
      if (tx_done && tx_error) both_hi <= both_hi + 1;
      if (clk_dl && !data_dl) inh_run <= inh_run + 1;
      else if (inh_run != 0) begin
         last_inh <= inh_run;
         inh_run  <= 0;
      end
      if (clk_dl && data_dl) req_cnt <= req_cnt + 1;
      if (clk_dl && !clk_dl_prev) inh_starts <= inh_starts + 1;
      clk_dl_prev <= clk_dl;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start_tx(input logic [7:0] b);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx_ready) break;
      end
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Wait until host released clock and holds start bit (SEND)
   task automatic wait_send(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!clk_dl && data_dl) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Device: 10 clocks sampling data on the high phase, then the ACK clock
   task automatic dev_frame(input bit ack_val, input int stop_after, input bit inject,
                            output logic [9:0] bits);
      bit ok;
      bits = '0;
      wait_send(ok);
      check_eq("rts_seen", 32'(ok), 32'd1);
      if (!ok) return;
      repeat (10) @(negedge clk);
      for (int i = 1; i <= 10; i++) begin
         dev_clk_low = 1'b1;
         repeat (20) @(negedge clk);
         if (i == stop_after) return;
         if (inject && i == 3) begin
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
         end
         dev_clk_low = 1'b0;
         repeat (10) @(negedge clk);
         bits[i-1] = ps2_data_in;
         repeat (10) @(negedge clk);
      end
      if (!ack_val) dev_data_low = 1'b1;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk);
      dev_data_low = 1'b0;
   endtask

   task automatic wait_result(input int d0, input int e0);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done_cnt != d0 || err_cnt != e0) break;
      end
      repeat (5) @(negedge clk);
   endtask

   // Full good frame: check bits, parity, stop and a single tx_done
   task automatic good_frame(input string tag, input logic [7:0] b, input logic par);
      logic [9:0] bits;
      int d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(b);
      dev_frame(1'b0, 0, 1'b0, bits);
      wait_result(d0, e0);
      check_eq({tag, "_data"}, 32'(bits[7:0]), 32'(b));
      check_eq({tag, "_parity"}, 32'(bits[8]), 32'(par));
      check_eq({tag, "_stop"}, 32'(bits[9]), 32'd1);
      check_eq({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
      check_eq({tag, "_err"}, 32'(err_cnt - e0), 32'd0);
      check_eq({tag, "_ready"}, 32'(tx_ready), 32'd1);
   endtask

   initial begin
      logic [9:0] bits;
      logic [9:0] bits2;
      int d0, e0, r0, s0, n;
      bit ok;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_ready", 32'(tx_ready), 32'd1);
      check_eq("rst_clk_dl", 32'(clk_dl), 32'd0);
      check_eq("rst_data_dl", 32'(data_dl), 32'd0);
      check_eq("rst_done", 32'(tx_done), 32'd0);
      check_eq("rst_error", 32'(tx_error), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // 0xED: inhibit length and start-bit phase, then frame content
      r0 = req_cnt;
      good_frame("ed", CMD_SET_LEDS, 1'b1);
      check_eq("ed_inhibit_cycles", 32'(last_inh), 32'(INH));
      check_eq("ed_req_cycles", 32'(req_cnt - r0), 32'd1);

      good_frame("zero", 8'h00, 1'b1);
      good_frame("seven", 8'h07, 1'b0);

`ifndef PS2_TX_RESEND_EN
      // NACK
      d0 = done_cnt; e0 = err_cnt;
      start_tx(8'hF4);
      dev_frame(1'b1, 0, 1'b0, bits);
      wait_result(d0, e0);
      check_eq("nack_err", 32'(err_cnt - e0), 32'd1);
      check_eq("nack_done", 32'(done_cnt - d0), 32'd0);
      check_eq("nack_clk_dl", 32'(clk_dl), 32'd0);
      check_eq("nack_data_dl", 32'(data_dl), 32'd0);

      // Timeout: device never clocks
      start_tx(8'h3C);
      wait_send(ok);
      check_eq("to_rts_seen", 32'(ok), 32'd1);
      n = -1;
      for (int i = 1; i <= int'(TO) + 100; i++) begin
         @(negedge clk);
         if (tx_error) begin
            n = i;
            break;
         end
      end
      check_eq("timeout_cycles", 32'(n), 32'(TO));
      check_eq("to_clk_dl", 32'(clk_dl), 32'd0);
      check_eq("to_data_dl", 32'(data_dl), 32'd0);
      repeat (5) @(negedge clk);
`else
      // First NACK resends the same byte, then ACK
      d0 = done_cnt; e0 = err_cnt; s0 = inh_starts;
      start_tx(8'h5A);
      dev_frame(1'b1, 0, 1'b0, bits);
      dev_frame(1'b0, 0, 1'b0, bits2);
      wait_result(d0, e0);
      check_eq("rs_first_data", 32'(bits[7:0]), 32'h5A);
      check_eq("rs_second_data", 32'(bits2[7:0]), 32'h5A);
      check_eq("rs_inhibits", 32'(inh_starts - s0), 32'd2);
      check_eq("rs_done", 32'(done_cnt - d0), 32'd1);
      check_eq("rs_err", 32'(err_cnt - e0), 32'd0);

      // Two NACKs -> one error
      d0 = done_cnt; e0 = err_cnt;
      start_tx(8'hF4);
      dev_frame(1'b1, 0, 1'b0, bits);
      dev_frame(1'b1, 0, 1'b0, bits2);
      wait_result(d0, e0);
      check_eq("rs2_err", 32'(err_cnt - e0), 32'd1);
      check_eq("rs2_done", 32'(done_cnt - d0), 32'd0);
      check_eq("rs2_clk_dl", 32'(clk_dl), 32'd0);
      check_eq("rs2_data_dl", 32'(data_dl), 32'd0);
`endif

      // Async reset after fall 5
      start_tx(8'h96);
      dev_frame(1'b0, 5, 1'b0, bits);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_clk_dl", 32'(clk_dl), 32'd0);
      check_eq("arst_data_dl", 32'(data_dl), 32'd0);
      check_eq("arst_ready", 32'(tx_ready), 32'd1);
      dev_clk_low = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      good_frame("ff", CMD_RESET, 1'b1);

      // tx_valid during SEND is ignored
      d0 = done_cnt; e0 = err_cnt; s0 = inh_starts;
      start_tx(8'hA3);
      dev_frame(1'b0, 0, 1'b1, bits);
      wait_result(d0, e0);
      repeat (60) @(negedge clk);
      check_eq("inj_data", 32'(bits[7:0]), 32'hA3);
      check_eq("inj_parity", 32'(bits[8]), 32'd1);
      check_eq("inj_done", 32'(done_cnt - d0), 32'd1);
      check_eq("inj_frames", 32'(inh_starts - s0), 32'd1);
      check_eq("inj_clk_dl", 32'(clk_dl), 32'd0);

      check_eq("done_error_overlap", 32'(both_hi), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
